// File: rtl/glitch_sweep_ctrl.sv
// Purpose: steps glitch engine delay (outer loop) and pulse width (inner loop)
//          over a 2-D grid, one arm/fire/disarm/settle shot per grid point.
// Latency/backpressure: outputs registered, 1 cycle after the deciding input;
//          paced by engine state (cooldown/idle) and by the fire timeout.
//
// Ports:
//   sysclk, rst          clock, asynchronous active-high reset
//   i_start, i_abort     begin sweep (ignored while busy), terminate sweep
//   i_delay_*/i_width_*  start value, step and point count per axis
//   i_settle, i_timeout  idle cycles between shots, fire timeout (0 = none)
//   i_gl_state           engine state: 0 idle, 1 armed, 2 wait, 3 fire, 4 cooldown
//   o_delay, o_width     current point values driven to the engine
//   o_arm, o_busy        engine arm request, sweep in progress
//   o_shot, o_shot_timeout, o_done   single-cycle event pulses
//   o_delay_idx, o_width_idx         current grid indices
module glitch_sweep_ctrl #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          sysclk,
   input  logic          rst,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [DW-1:0] i_delay_start,
   input  logic [DW-1:0] i_delay_step,
   input  logic [CW-1:0] i_delay_count,
   input  logic [DW-1:0] i_width_start,
   input  logic [DW-1:0] i_width_step,
   input  logic [CW-1:0] i_width_count,
   input  logic [15:0]   i_settle,
   input  logic [31:0]   i_timeout,
   input  logic [3:0]    i_gl_state,
   output logic [DW-1:0] o_delay,
   output logic [DW-1:0] o_width,
   output logic          o_arm,
   output logic          o_busy,
   output logic          o_shot,
   output logic          o_shot_timeout,
   output logic          o_done,
   output logic [CW-1:0] o_delay_idx,
   output logic [CW-1:0] o_width_idx
);

   localparam logic [3:0] GL_IDLE     = 4'd0;
   localparam logic [3:0] GL_COOLDOWN = 4'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT_FIRE,
      S_DISARM,
      S_SETTLE,
      S_STEP,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   timer_q, timer_d;

   // Sweep configuration captured on the accepted start.
   logic [DW-1:0] delay_step_q, delay_step_d;
   logic [DW-1:0] width_start_q, width_start_d;
   logic [DW-1:0] width_step_q, width_step_d;
   logic [CW-1:0] delay_count_q, delay_count_d;
   logic [CW-1:0] width_count_q, width_count_d;
   logic [15:0]   settle_q, settle_d;
   logic [31:0]   timeout_q, timeout_d;

   // Registered outputs.
   logic [DW-1:0] delay_q, delay_d;
   logic [DW-1:0] width_q, width_d;
   logic [CW-1:0] delay_idx_q, delay_idx_d;
   logic [CW-1:0] width_idx_q, width_idx_d;
   logic          arm_q, arm_d;
   logic          busy_q, busy_d;
   logic          shot_q, shot_d;
   logic          shot_to_q, shot_to_d;
   logic          done_q, done_d;

   logic          cooldown_seen;
   logic          timeout_hit;
   logic          settle_last;
   logic          width_more;
   logic          delay_more;

   assign cooldown_seen = (i_gl_state == GL_COOLDOWN);
   assign timeout_hit   = (timeout_q != 32'd0) && (timer_q == timeout_q - 32'd1);
   // A zero settle still spends one cycle in SETTLE.
   assign settle_last   = (settle_q == 16'd0) ||
                          (timer_q == {16'd0, settle_q - 16'd1});
   assign width_more    = (width_idx_q < width_count_q - CW'(1));
   assign delay_more    = (delay_idx_q < delay_count_q - CW'(1));

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      delay_step_d  = delay_step_q;
      width_start_d = width_start_q;
      width_step_d  = width_step_q;
      delay_count_d = delay_count_q;
      width_count_d = width_count_q;
      settle_d      = settle_q;
      timeout_d     = timeout_q;
      delay_d       = delay_q;
      width_d       = width_q;
      delay_idx_d   = delay_idx_q;
      width_idx_d   = width_idx_q;
      shot_d        = 1'b0;
      shot_to_d     = 1'b0;

      if (i_abort) begin
         // Abort beats everything, including a same-cycle start; values hold.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  delay_step_d  = i_delay_step;
                  width_start_d = i_width_start;
                  width_step_d  = i_width_step;
                  delay_count_d = i_delay_count;
                  width_count_d = i_width_count;
                  settle_d      = i_settle;
                  timeout_d     = i_timeout;
                  delay_d       = i_delay_start;
                  width_d       = i_width_start;
                  delay_idx_d   = '0;
                  width_idx_d   = '0;
                  if ((i_delay_count == '0) || (i_width_count == '0)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ARM;
                  end
               end
            end
            S_ARM: begin
               timer_d = 32'd0;
               state_d = S_WAIT_FIRE;
            end
            S_WAIT_FIRE: begin
               timer_d = timer_q + 32'd1;
               // Cooldown is checked first so a fire on the timeout cycle
               // is still reported as a completed shot.
               if (cooldown_seen) begin
                  shot_d  = 1'b1;
                  state_d = S_DISARM;
               end else if (timeout_hit) begin
                  shot_to_d = 1'b1;
                  state_d   = S_DISARM;
               end
            end
            S_DISARM: begin
               if (i_gl_state == GL_IDLE) begin
                  timer_d = 32'd0;
                  state_d = S_SETTLE;
               end
            end
            S_SETTLE: begin
               timer_d = timer_q + 32'd1;
               if (settle_last) begin
                  state_d = S_STEP;
               end
            end
            S_STEP: begin
               if (width_more) begin
                  width_idx_d = width_idx_q + CW'(1);
                  width_d     = width_q + width_step_q;
                  state_d     = S_ARM;
               end else if (delay_more) begin
                  width_idx_d = '0;
                  width_d     = width_start_q;
                  delay_idx_d = delay_idx_q + CW'(1);
                  delay_d     = delay_q + delay_step_q;
                  state_d     = S_ARM;
               end else begin
                  state_d = S_DONE;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Level outputs follow the state being entered, so they change only
      // on state entry and are constant for the whole stay in a state.
      arm_d  = (state_d == S_WAIT_FIRE);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         timer_q       <= 32'd0;
         delay_step_q  <= '0;
         width_start_q <= '0;
         width_step_q  <= '0;
         delay_count_q <= '0;
         width_count_q <= '0;
         settle_q      <= 16'd0;
         timeout_q     <= 32'd0;
         delay_q       <= '0;
         width_q       <= '0;
         delay_idx_q   <= '0;
         width_idx_q   <= '0;
         arm_q         <= 1'b0;
         busy_q        <= 1'b0;
         shot_q        <= 1'b0;
         shot_to_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         delay_step_q  <= delay_step_d;
         width_start_q <= width_start_d;
         width_step_q  <= width_step_d;
         delay_count_q <= delay_count_d;
         width_count_q <= width_count_d;
         settle_q      <= settle_d;
         timeout_q     <= timeout_d;
         delay_q       <= delay_d;
         width_q       <= width_d;
         delay_idx_q   <= delay_idx_d;
         width_idx_q   <= width_idx_d;
         arm_q         <= arm_d;
         busy_q        <= busy_d;
         shot_q        <= shot_d;
         shot_to_q     <= shot_to_d;
         done_q        <= done_d;
      end
   end

   assign o_delay        = delay_q;
   assign o_width        = width_q;
   assign o_arm          = arm_q;
   assign o_busy         = busy_q;
   assign o_shot         = shot_q;
   assign o_shot_timeout = shot_to_q;
   assign o_done         = done_q;
   assign o_delay_idx    = delay_idx_q;
   assign o_width_idx    = width_idx_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Purpose: directed bench for glitch_sweep_ctrl with an engine model and a
//          queue of expected grid points consumed on every shot/timeout.
// Timing: inputs driven and outputs sampled on the falling edge.
module tb_glitch_sweep_ctrl;

   logic        sysclk;
   logic        rst;
   logic        i_start, i_abort;
   logic [31:0] i_delay_start, i_delay_step, i_width_start, i_width_step;
   logic [15:0] i_delay_count, i_width_count, i_settle;
   logic [31:0] i_timeout;
   logic [3:0]  i_gl_state = 4'd0;
   logic [31:0] o_delay, o_width;
   logic        o_arm, o_busy, o_shot, o_shot_timeout, o_done;
   logic [15:0] o_delay_idx, o_width_idx;

   glitch_sweep_ctrl dut (
      .sysclk(sysclk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
      .i_delay_start(i_delay_start), .i_delay_step(i_delay_step),
      .i_delay_count(i_delay_count), .i_width_start(i_width_start),
      .i_width_step(i_width_step), .i_width_count(i_width_count),
      .i_settle(i_settle), .i_timeout(i_timeout), .i_gl_state(i_gl_state),
      .o_delay(o_delay), .o_width(o_width), .o_arm(o_arm), .o_busy(o_busy),
      .o_shot(o_shot), .o_shot_timeout(o_shot_timeout), .o_done(o_done),
      .o_delay_idx(o_delay_idx), .o_width_idx(o_width_idx)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] w;
      logic [15:0] di;
      logic [15:0] wi;
   } pt_t;

   pt_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Engine model: mode 0 reaches cooldown eng_lat cycles after arm and
   // returns to idle 2 cycles after disarm; mode 1 sits in armed forever.
   int eng_mode = 0;
   int eng_lat  = 20;
   int eng_cnt  = 0;
   int eng_idle = 0;
   always @(negedge sysclk) begin
      if (eng_mode == 1) begin
         i_gl_state = o_arm ? 4'd1 : 4'd0;
      end else if (o_arm) begin
         eng_cnt++;
         eng_idle = 0;
         i_gl_state = (eng_cnt >= eng_lat) ? 4'd4 : 4'd1;
      end else if (i_gl_state != 4'd0) begin
         eng_idle++;
         if (eng_idle >= 2) begin
            i_gl_state = 4'd0;
            eng_cnt = 0;
         end
      end else begin
         eng_cnt  = 0;
         eng_idle = 0;
      end
   end

   // Output monitor and scoreboard consumer.
   int   cyc = 0, shot_cnt = 0, to_cnt = 0, done_cnt = 0, arm_rise_cnt = 0;
   int   arm_rise_cyc = 0, arm_fall_cyc = -1, cur_timeout = 0, gap_exp = 8;
   bit   chk_gap = 0;
   logic arm_prev = 1'b0;
   always @(negedge sysclk) begin
      pt_t e;
      cyc++;
      if (!rst) begin
         if (o_arm && !arm_prev) begin
            arm_rise_cnt++;
            arm_rise_cyc = cyc;
            if (chk_gap && arm_fall_cyc >= 0)
               check("arm_low_gap", 64'(cyc - arm_fall_cyc), 64'(gap_exp));
         end
         if (!o_arm && arm_prev) arm_fall_cyc = cyc;
         if (o_shot || o_shot_timeout) begin
            if (o_shot) shot_cnt++;
            else begin
               to_cnt++;
               check("timeout_latency", 64'(cyc - arm_rise_cyc), 64'(cur_timeout));
            end
            check("arm_low_at_shot", 64'(o_arm), 64'd0);
            n_tests++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_shot: observed delay 0x%0h width 0x%0h expected none", o_delay, o_width);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("shot_delay", 64'(o_delay), 64'(e.d));
               check("shot_width", 64'(o_width), 64'(e.w));
               check("shot_didx", 64'(o_delay_idx), 64'(e.di));
               check("shot_widx", 64'(o_width_idx), 64'(e.wi));
            end
         end
         if (o_done) done_cnt++;
      end
      arm_prev = o_arm;
   end

   // Drives a start pulse and queues every grid point in sweep order.
   task automatic start_sweep(input logic [31:0] ds, input logic [31:0] dst, input int dc,
                              input logic [31:0] ws, input logic [31:0] wst, input int wc,
                              input int settle, input int tmo);
      @(negedge sysclk);
      arm_fall_cyc  = -1;
      cur_timeout   = tmo;
      i_delay_start = ds;  i_delay_step = dst; i_delay_count = 16'(dc);
      i_width_start = ws;  i_width_step = wst; i_width_count = 16'(wc);
      i_settle      = 16'(settle);
      i_timeout     = 32'(tmo);
      i_start       = 1'b1;
      for (int di = 0; di < dc; di++)
         for (int wi = 0; wi < wc; wi++)
            exp_q.push_back('{d: ds + dst * 32'(di), w: ws + wst * 32'(wi),
                              di: 16'(di), wi: 16'(wi)});
      @(negedge sysclk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int d0 = done_cnt;
      for (int i = 0; i < bound && done_cnt == d0; i++) @(negedge sysclk);
      check(tag, 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic pulse_abort();
      @(negedge sysclk);
      i_abort = 1'b1;
      @(negedge sysclk);
      i_abort = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, t0, a0, d0;
      rst = 1'b1; i_start = 0; i_abort = 0;
      i_delay_start = 0; i_delay_step = 0; i_delay_count = 0;
      i_width_start = 0; i_width_step = 0; i_width_count = 0;
      i_settle = 0; i_timeout = 0;
      repeat (3) @(negedge sysclk);
      check("rst_delay", 64'(o_delay), 64'd0);
      check("rst_width", 64'(o_width), 64'd0);
      check("rst_flags", 64'({o_arm, o_busy, o_shot, o_shot_timeout, o_done}), 64'd0);
      check("rst_idx", 64'({o_delay_idx, o_width_idx}), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge sysclk);

      // Basic 2x3 sweep.
      eng_mode = 0; chk_gap = 1;
      s0 = shot_cnt; t0 = to_cnt; a0 = arm_rise_cnt;
      start_sweep(100, 10, 2, 5, 1, 3, 4, 0);
      check("basic_busy", 64'(o_busy), 64'd1);
      wait_done("basic_done", 2000);
      @(negedge sysclk);
      check("basic_shots", 64'(shot_cnt - s0), 64'd6);
      check("basic_timeouts", 64'(to_cnt - t0), 64'd0);
      check("basic_arms", 64'(arm_rise_cnt - a0), 64'd6);
      check("basic_queue", 64'(exp_q.size()), 64'd0);
      check("basic_hold", {o_delay, o_width}, {32'd110, 32'd7});
      check("basic_hold_idx", 64'({o_delay_idx, o_width_idx}), {32'd0, 16'd1, 16'd2});
      check("basic_idle", 64'({o_busy, o_arm}), 64'd0);

      // Timeout path, engine stuck armed.
      eng_mode = 1; chk_gap = 0;
      s0 = shot_cnt; t0 = to_cnt;
      start_sweep(200, 0, 1, 7, 3, 2, 0, 50);
      wait_done("to_done", 1000);
      check("to_count", 64'(to_cnt - t0), 64'd2);
      check("to_shots", 64'(shot_cnt - s0), 64'd0);
      check("to_queue", 64'(exp_q.size()), 64'd0);
      check("to_width", 64'(o_width), 64'd10);

      // Infinite timeout holds in WAIT_FIRE.
      t0 = to_cnt;
      start_sweep(1, 1, 1, 1, 1, 1, 0, 0);
      repeat (10000) @(negedge sysclk);
      check("inf_armed", 64'({o_arm, o_busy}), 64'd3);
      check("inf_no_timeout", 64'(to_cnt - t0), 64'd0);
      pulse_abort();
      check("inf_abort", 64'({o_arm, o_busy}), 64'd0);
      exp_q.delete();
      eng_mode = 0;
      repeat (5) @(negedge sysclk);

      // Zero width count: immediate done, no shot.
      s0 = shot_cnt; a0 = arm_rise_cnt; d0 = done_cnt;
      start_sweep(3, 1, 2, 2, 1, 0, 0, 0);
      check("zero_done", 64'({o_done, o_busy, o_arm}), 64'd4);
      check("zero_values", {o_delay, o_width}, {32'd3, 32'd2});
      @(negedge sysclk);
      check("zero_done_pulse", 64'(o_done), 64'd0);
      repeat (10) @(negedge sysclk);
      check("zero_no_arm", 64'(arm_rise_cnt - a0), 64'd0);
      check("zero_no_shot", 64'(shot_cnt - s0), 64'd0);
      check("zero_one_done", 64'(done_cnt - d0), 64'd1);

      // Abort during WAIT_FIRE of point (1,1), then restart.
      chk_gap = 1;
      s0 = shot_cnt; a0 = arm_rise_cnt;
      start_sweep(100, 10, 2, 5, 1, 3, 4, 0);
      for (int i = 0; i < 2000 && (shot_cnt - s0 < 4 || arm_rise_cnt - a0 < 5); i++)
         @(negedge sysclk);
      check("abort_reached", 64'(arm_rise_cnt - a0), 64'd5);
      repeat (5) @(negedge sysclk);
      d0 = done_cnt;
      pulse_abort();
      check("abort_flags", 64'({o_arm, o_busy}), 64'd0);
      check("abort_idx", 64'({o_delay_idx, o_width_idx}), {32'd0, 16'd1, 16'd1});
      check("abort_values", {o_delay, o_width}, {32'd110, 32'd6});
      a0 = arm_rise_cnt;
      repeat (40) @(negedge sysclk);
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_stays_idle", 64'(arm_rise_cnt - a0), 64'd0);
      exp_q.delete();
      s0 = shot_cnt;
      start_sweep(100, 10, 2, 5, 1, 3, 4, 0);
      check("restart_idx", 64'({o_delay_idx, o_width_idx}), 64'd0);
      check("restart_values", {o_delay, o_width}, {32'd100, 32'd5});
      wait_done("restart_done", 2000);
      check("restart_shots", 64'(shot_cnt - s0), 64'd6);

      // Delay wrap.
      start_sweep(32'hFFFF_FFFF, 1, 2, 9, 0, 1, 4, 0);
      wait_done("wrap_done", 1000);
      check("wrap_queue", 64'(exp_q.size()), 64'd0);
      check("wrap_final_delay", 64'(o_delay), 64'd0);

      // Cooldown and timeout on the same cycle; start while busy ignored.
      s0 = shot_cnt; t0 = to_cnt; a0 = arm_rise_cnt;
      start_sweep(300, 5, 1, 40, 2, 2, 4, 20);
      for (int i = 0; i < 200 && arm_rise_cnt == a0; i++) @(negedge sysclk);
      @(negedge sysclk);
      i_delay_start = 999; i_delay_count = 5; i_width_count = 5; i_start = 1'b1;
      @(negedge sysclk);
      i_start = 1'b0;
      wait_done("prio_done", 1000);
      check("prio_shots", 64'(shot_cnt - s0), 64'd2);
      check("prio_timeouts", 64'(to_cnt - t0), 64'd0);
      check("prio_queue", 64'(exp_q.size()), 64'd0);
      check("prio_delay", 64'(o_delay), 64'd300);

      // Asynchronous reset in SETTLE.
      chk_gap = 0;
      s0 = shot_cnt;
      start_sweep(500, 1, 2, 1, 1, 2, 20, 0);
      for (int i = 0; i < 200 && shot_cnt == s0; i++) @(negedge sysclk);
      repeat (5) @(negedge sysclk);
      check("pre_rst_busy", 64'(o_busy), 64'd1);
      #3 rst = 1'b1;
      #1;
      check("arst_values", {o_delay, o_width}, 64'd0);
      check("arst_flags", 64'({o_arm, o_busy, o_shot, o_shot_timeout, o_done}), 64'd0);
      check("arst_idx", 64'({o_delay_idx, o_width_idx}), 64'd0);
      @(negedge sysclk);
      rst = 1'b0;
      exp_q.delete();
      a0 = arm_rise_cnt; d0 = done_cnt;
      repeat (30) @(negedge sysclk);
      check("post_rst_idle", 64'({o_busy, o_arm}), 64'd0);
      check("post_rst_no_arm", 64'(arm_rise_cnt - a0), 64'd0);
      check("post_rst_no_done", 64'(done_cnt - d0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/glitch_sweep_ctrl.md
Name: glitch_sweep_ctrl

Overview:
- Autonomous parameter-sweep scheduler for the glitch engine.
- Steps the pre-fire delay (clock-edge target) and the pulse width over a 2-D grid, one shot per point.
- Per shot: arm the engine, wait for it to fire and reach cooldown, disarm, wait a settle period, then advance.
- Sits between the command decoder, which supplies the sweep config, and the glitch engine, whose delay/width/arm inputs it drives while busy. Runs in the sysclk domain.

Parameters:
- DW, 32, width of delay/width values and their steps.
- CW, 16, width of point counts and indices.

Ports:
- sysclk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_start  in  1  1-cycle pulse; begin sweep (ignored while busy)
- i_abort  in  1  level/pulse; terminate sweep
- i_delay_start  in  DW  first delay value
- i_delay_step  in  DW  delay increment per outer step
- i_delay_count  in  CW  number of delay points
- i_width_start  in  DW  first pulse width
- i_width_step  in  DW  width increment per inner step
- i_width_count  in  CW  number of width points
- i_settle  in  16  idle cycles between shots
- i_timeout  in  32  max cycles to wait for a fire; 0 = infinite
- i_gl_state  in  4  engine state: 0 idle, 1 armed, 2 waiting, 3 firing, 4 cooldown
- o_delay  out  DW  current delay to engine
- o_width  out  DW  current width to engine
- o_arm  out  1  1 = engine armed (inverse of engine disarm)
- o_busy  out  1  sweep in progress
- o_shot  out  1  1-cycle pulse: shot completed
- o_shot_timeout  out  1  1-cycle pulse: shot abandoned on timeout
- o_done  out  1  1-cycle pulse: sweep completed normally
- o_delay_idx  out  CW  current delay index
- o_width_idx  out  CW  current width index

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including o_delay, o_width and both indices. Cycle timer cleared.
- All outputs are registered. Config inputs are latched on the accepted i_start; later changes have no effect until the next start.
- States: IDLE, ARM, WAIT_FIRE, DISARM, SETTLE, STEP, DONE.
- IDLE (o_busy=0, o_arm=0): on i_start, latch config, set indices=0, o_delay=delay_start, o_width=width_start.
  - If either count==0: go to DONE (zero shots).
  - Otherwise: go to ARM.
- ARM: o_arm<=1; clear timer; go to WAIT_FIRE next cycle.
- WAIT_FIRE (o_arm=1): timer increments each cycle.
  - i_gl_state==4: pulse o_shot, go to DISARM.
  - Else if i_timeout!=0 and timer==i_timeout-1: pulse o_shot_timeout, go to DISARM.
  - If both occur in the same cycle, cooldown wins: o_shot only.
- DISARM: o_arm<=0; stay until i_gl_state==0; then clear timer and go to SETTLE.
- SETTLE: stay i_settle cycles (0 means pass through in 1 cycle), then go to STEP.
- STEP (single cycle), inner loop = width, outer loop = delay:
  - If width_idx < width_count-1: width_idx++, o_width+=width_step, go to ARM.
  - Else if delay_idx < delay_count-1: width_idx=0, o_width=width_start, delay_idx++, o_delay+=delay_step, go to ARM.
  - Else: go to DONE.
- DONE: o_done=1 for exactly 1 cycle, o_busy=0, go to IDLE. o_delay, o_width and the indices hold their last values.
- Arithmetic: additions wrap modulo 2^DW with no saturation. Index compares are unsigned.
- o_busy=1 in every state except IDLE and DONE.
- Total shots = delay_count * width_count.
- i_abort: highest priority in every state. Next cycle: o_arm=0, state IDLE, no o_done. Values and indices hold. A same-cycle i_start is ignored.
- i_start while busy is ignored.
- o_arm changes only on state entry; it never glitches within a state.

Test Plan:
- Basic sweep: delay 100/+10/count 2, width 5/+1/count 3, settle 4; model the engine reaching cooldown 20 cycles after arm, then idle 2 cycles later -> 6 o_shot pulses; (delay,width) sequence (100,5)(100,6)(100,7)(110,5)(110,6)(110,7); one o_done after the last settle; o_arm low during every settle.
- Timeout: i_timeout=50, engine never leaves state 1 -> o_shot_timeout exactly 50 cycles after ARM entry, o_arm drops, sweep continues; with i_timeout=0 the FSM holds in WAIT_FIRE for 10000 cycles.
- Zero count: width_count=0, start -> o_done 1 cycle later, no o_arm and no o_shot.
- Abort mid-shot: abort during WAIT_FIRE of point (1,1) -> o_arm=0 next cycle, o_busy=0, no o_done, indices read 1/1; a fresh start restarts at index 0/0.
- Wrap and priority: delay_start=0xFFFFFFFF, step 1, count 2 -> second delay 0x00000000; cooldown and timeout in the same cycle -> o_shot only; i_start during busy -> no effect.
- Async reset asserted in SETTLE, not aligned to a clock edge -> all outputs 0 immediately; after release, state IDLE.
